risc_core_p: RTL and testbench

- Parametrised single-clock successor to the team's 8-bit accumulator RISC CPU.
- Same 8-opcode ISA (HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP), but data width, address width and fetch beat count are parameters.
- The multi-phase clock generator is replaced by a single-clock Moore FSM.
- Adds a mem_ready wait-state handshake, split read/write data buses (top level does any tristating), and resume-from-halt.

---
 rtl/risc_core_pkg.sv | 17 +
 rtl/risc_core_p_alu.sv | 20 ++
 rtl/risc_core_p.sv | 92 +++++++++
 tb/tb_risc_core_p.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/risc_core_pkg.sv
// risc_core_pkg: opcodes, FSM state encoding and decode helper for risc_core_p
package risc_core_pkg;
    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_HALTED} state_t;

    function automatic logic is_load(input logic [2:0] op);
        return op inside {OP_ADD, OP_AND, OP_XOR, OP_LDA};
    endfunction
endpackage

// File: rtl/risc_core_p_alu.sv
// risc_alu_p: accumulator datapath for the memory-operand instructions
module risc_alu_p
    import risc_core_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [2:0]        opcode,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] result,
    output logic              zero
);
    always_comb begin
        result = opcode == OP_ADD ? acc + data :
                 opcode == OP_AND ? acc & data :
                 opcode == OP_XOR ? acc ^ data :
                 opcode == OP_LDA ? data : acc;
        zero   = acc == '0;
    end
endmodule

// File: rtl/risc_core_p.sv
// risc_core_p: parametrised single-clock accumulator CPU with ready handshake and resume-from-halt
module risc_core_p
    import risc_core_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 13,
    parameter int FETCH_BEATS = 2,
    parameter int RESET_VEC   = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic              resume,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              halt,
    output logic [DATA_W-1:0] acc_out
);
    localparam int IW = FETCH_BEATS * DATA_W;
    localparam int BW = FETCH_BEATS > 1 ? $clog2(FETCH_BEATS) : 1;
    localparam logic [BW-1:0]     LAST   = BW'(FETCH_BEATS - 1);
    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] SKIP   = ADDR_W'(FETCH_BEATS);

    if (IW < ADDR_W + 3) begin : g_width_err
        $error("risc_core_p: FETCH_BEATS*DATA_W must be at least ADDR_W+3");
    end

    state_t            state;
    logic [BW-1:0]     beat;
    logic [ADDR_W-1:0] pc;
    logic [IW-1:0]     ir;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] alu_res;
    logic              acc_zero;
    logic [2:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic              mem_op;

    assign opcode  = ir[ADDR_W+2:ADDR_W];
    assign operand = ir[ADDR_W-1:0];
    assign mem_op  = is_load(opcode) || opcode == OP_STO;

    risc_alu_p #(.DATA_W(DATA_W)) u_alu (
        .opcode(opcode),
        .acc   (acc),
        .data  (mem_rdata),
        .result(alu_res),
        .zero  (acc_zero)
    );

    // Strobes are gated by reset so a pending access is abandoned the instant reset asserts
    always_comb begin
        mem_rd    = reset && (state == ST_FETCH || (state == ST_EXEC && is_load(opcode)));
        mem_wr    = reset && state == ST_EXEC && opcode == OP_STO;
        address   = state == ST_EXEC ? operand : pc;
        mem_wdata = acc;
        halt      = state == ST_HALTED;
        acc_out   = acc;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_FETCH;
            beat  <= '0;
            pc    <= PC_RST;
            ir    <= '0;
            acc   <= '0;
        end else begin
            case (state)
                ST_FETCH: if (mem_ready) begin
                    ir   <= IW'({ir, mem_rdata});
                    pc   <= pc + ADDR_W'(1);
                    beat <= beat == LAST ? '0 : beat + BW'(1);
                    if (beat == LAST) state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (opcode == OP_SKZ && acc_zero) pc <= pc + SKIP;
                    if (opcode == OP_JMP) pc <= operand;
                    if (is_load(opcode) && mem_ready) acc <= alu_res;
                    if (opcode == OP_HLT) state <= ST_HALTED;
                    else if (!mem_op || mem_ready) state <= ST_FETCH;
                end
                ST_HALTED: if (resume) state <= ST_FETCH;
                default: state <= ST_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_risc_core_p.sv
// tb_risc_core_p: scoreboard bench for risc_core_p (default 8-bit core and a 16-bit single-beat core)
module tb_risc_core_p;
    typedef struct packed {
        logic        wr;
        logic [12:0] addr;
        logic [7:0]  data;
    } xact_t;

    logic        clk, rst_n, rst1_n;
    logic        ready0, resume0, rd0, wr0, halt0;
    logic [12:0] addr0;
    logic [7:0]  rdata0, wdata0, acc0;
    logic        ready1, resume1, rd1, wr1, halt1;
    logic [12:0] addr1;
    logic [15:0] rdata1, wdata1, acc1;
    logic [7:0]  mem0 [0:8191];
    logic [15:0] mem1 [0:8191];
    xact_t       sb[$];
    int          n_checks = 0;
    int          n_errors = 0;

    risc_core_p dut0 (
        .clock(clk), .reset(rst_n), .mem_rdata(rdata0), .mem_ready(ready0), .resume(resume0),
        .mem_rd(rd0), .mem_wr(wr0), .address(addr0), .mem_wdata(wdata0), .halt(halt0), .acc_out(acc0)
    );

    risc_core_p #(.DATA_W(16), .ADDR_W(13), .FETCH_BEATS(1), .RESET_VEC(0)) dut1 (
        .clock(clk), .reset(rst1_n), .mem_rdata(rdata1), .mem_ready(ready1), .resume(resume1),
        .mem_rd(rd1), .mem_wr(wr1), .address(addr1), .mem_wdata(wdata1), .halt(halt1), .acc_out(acc1)
    );

    assign rdata0 = mem0[addr0];
    assign rdata1 = mem1[addr1];

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic wr, input logic [12:0] a, input logic [7:0] d);
        sb.push_back({wr, a, d});
    endtask

    // LDA 100 | ADD 101 | SKZ (skips JMP at 6) | STO 102 | HLT
    task automatic push_prog();
        push(0, 13'h000, 0); push(0, 13'h001, 0); push(0, 13'h100, 0);
        push(0, 13'h002, 0); push(0, 13'h003, 0); push(0, 13'h101, 0);
        push(0, 13'h004, 0); push(0, 13'h005, 0);
        push(0, 13'h008, 0); push(0, 13'h009, 0); push(1, 13'h102, 8'h00);
        push(0, 13'h00A, 0); push(0, 13'h00B, 0);
    endtask

    task automatic wait_halt(input string tag);
        int n = 0;
        while (!halt0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 32'(halt0), 1);
        check({tag, "_drained"}, sb.size(), 0);
    endtask

    // The memory sees the bus directly, so a write strobe leaking through reset would land here
    always @(posedge clk) if (wr0 && ready0) mem0[addr0] <= wdata0;

    always @(negedge clk) begin : monitor
        xact_t e;
        if (ready0 && (rd0 || wr0)) begin
            if (sb.size() != 0) e = sb.pop_front();
            else e = '1;
            check("rd_wr_excl", 32'(rd0 & wr0), 0);
            check("xact_kind", 32'(wr0), 32'(e.wr));
            check("xact_addr", 32'(addr0), 32'(e.addr));
            if (wr0) check("xact_wdata", 32'(wdata0), 32'(e.data));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_cycles;
        logic found;
        for (int i = 0; i < 8192; i++) begin
            mem0[i] = 8'h00;
            mem1[i] = 16'h0000;
        end
        {mem0[0], mem0[1], mem0[2], mem0[3], mem0[4], mem0[5]} = {8'hA1, 8'h00, 8'h41, 8'h01, 8'h20, 8'h00};
        {mem0[6], mem0[7], mem0[8], mem0[9], mem0[10], mem0[11]} = {8'hE0, 8'h00, 8'hC1, 8'h02, 8'h00, 8'h00};
        mem0[13'h100] = 8'h05;
        mem0[13'h101] = 8'hFB;
        {mem1[0], mem1[1], mem1[2], mem1[3], mem1[4]} = {16'hA100, 16'h4101, 16'h2000, 16'hE000, 16'h0000};
        mem1[13'h100] = 16'hFFFF;
        mem1[13'h101] = 16'h0001;
        rst_n = 0; rst1_n = 0;
        ready0 = 1; resume0 = 0; ready1 = 1; resume1 = 0;

        push_prog();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        repeat (5) @(posedge clk);
        #1 rst_n = 0;
        sb.delete();
        #1;
        check("rst_rd", 32'(rd0), 0);
        check("rst_wr", 32'(wr0), 0);
        check("rst_halt", 32'(halt0), 0);
        check("rst_addr", 32'(addr0), 0);
        check("rst_acc", 32'(acc0), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        push_prog();
        #1;
        check("rel_addr", 32'(addr0), 0);
        check("rel_rd", 32'(rd0), 1);
        check("rel_acc", 32'(acc0), 0);
        check("rel_halt", 32'(halt0), 0);

        // Cycles counted from reset assertion: 3 in reset, then 5 instructions x 3 cycles
        wr_cycles = 0;
        for (int c = 4; c <= 18; c++) begin
            @(posedge clk); #1;
            wr_cycles += int'(wr0);
            check("prog_acc", 32'(acc0), (c >= 6 && c <= 8) ? 'h05 : 'h00);
            check("prog_halt", 32'(halt0), 32'(c == 18));
        end
        check("sto_wr_cycles", wr_cycles, 1);
        check("sto_mem", 32'(mem0[13'h102]), 'h00);
        check("prog_drained", sb.size(), 0);

        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("halted_bus", 32'({halt0, rd0, wr0}), 'b100);
            check("halted_addr", 32'(addr0), 'h00C);
        end
        push(0, 13'h00C, 0); push(0, 13'h00D, 0);
        resume0 = 1;
        @(posedge clk); #1 resume0 = 0;
        check("resume_addr", 32'(addr0), 'h00C);
        check("resume_rd", 32'(rd0), 1);
        check("resume_halt", 32'(halt0), 0);
        wait_halt("resume_rehalt");
        check("resume_pc", 32'(addr0), 'h00E);

        rst_n = 0;
        sb.delete();
        @(posedge clk); #1 rst_n = 1;
        push_prog();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #1;
            found = rd0 && addr0 == 13'h100;
        end
        check("ws_found", 32'(found), 1);
        ready0 = 0;
        check("ws_addr", 32'(addr0), 'h100);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("ws_hold_addr", 32'(addr0), 'h100);
            check("ws_hold_rd", 32'(rd0), 1);
            check("ws_hold_acc", 32'(acc0), 0);
        end
        ready0 = 1;
        @(posedge clk); #1;
        check("ws_acc", 32'(acc0), 'h05);
        check("ws_next_addr", 32'(addr0), 'h002);
        wait_halt("ws_halt");

        rst_n = 0;
        sb.delete();
        mem0[13'h102] = 8'hAA;
        @(posedge clk); #1 rst_n = 1;
        push_prog();
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(posedge clk); #1;
            found = wr0;
        end
        check("sto_found", 32'(found), 1);
        check("sto_addr", 32'(addr0), 'h102);
        ready0 = 0;
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("sto_rst_wr", 32'(wr0), 0);
        check("sto_rst_rd", 32'(rd0), 0);
        sb.delete();
        ready0 = 1;
        @(posedge clk); #1;
        check("sto_no_write", 32'(mem0[13'h102]), 'hAA);
        rst_n = 1;
        push_prog();
        #1;
        check("sto_restart_addr", 32'(addr0), 0);
        check("sto_restart_rd", 32'(rd0), 1);
        wait_halt("sto_restart_halt");

        // 16-bit single-beat core: LDA FFFF, ADD 1 wraps to 0, SKZ skips JMP, HLT
        @(posedge clk); #1 rst1_n = 1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            check("w16_acc", 32'(acc1), (c == 2 || c == 3) ? 'hFFFF : 'h0000);
            check("w16_halt", 32'(halt1), 32'(c == 8));
        end
        check("w16_pc", 32'(addr1), 'h005);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
